// File: rtl/boule_rouge_scheduler.sv
// Red-ball spawn scheduler: paces spawn attempts, picks the lowest free ball slot
// and hands it an entry cube plus a 6-step random down-path from a Galois LFSR.
module boule_rouge_scheduler #(
  parameter int          N_BALL      = 2,
  parameter logic [31:0] SPAWN_DELAY = 32'd50000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   e_start_qb,
  input  logic                   e_pause_qb,
  input  logic                   e_resume_qb,
  input  logic                   KO_qb,
  input  logic                   freeze_power,
  input  logic [20:0]            xy_cube2,
  input  logic [20:0]            xy_cube3,
  input  logic [N_BALL-1:0]      br_end,
  output logic [N_BALL-1:0]      e_enable_br,
  output logic [6*N_BALL-1:0]    e_move_br,
  output logic [21*N_BALL-1:0]   e_XY0_br,
  output logic [N_BALL-1:0]      br_active,
  output logic [7:0]             spawn_cnt,
  output logic [1:0]             sched_state
);

  localparam logic [1:0]  ST_STOP  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_PAUSE = 2'd2;
  localparam logic [31:0] TERM     = SPAWN_DELAY - 32'd1;
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [1:0]             state_q, state_d;
  logic [31:0]            timer_q, timer_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [N_BALL-1:0]      end_q;
  logic [N_BALL-1:0]      active_q, active_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [N_BALL-1:0]      en_q, en_d;
  logic [6*N_BALL-1:0]    move_q, move_d;
  logic [21*N_BALL-1:0]   xy_q, xy_d;
  logic [N_BALL-1:0]      rise;
  logic [N_BALL-1:0]      pick;
  logic                   found;
  logic                   restart;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    rise   = br_end & ~end_q;

    // Lowest-index slot that is free as of the registered occupancy.
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_BALL; i++) begin
      if (!active_q[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end

    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q & ~rise;
    cnt_d    = cnt_q;
    en_d     = '0;
    move_d   = move_q;
    xy_d     = xy_q;
    restart  = 1'b0;

    case (state_q)
      ST_STOP: begin
        timer_d = '0;
        if (e_start_qb) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end
      end
      ST_RUN: begin
        if (e_start_qb) begin
          restart = 1'b1;
        end else if (e_pause_qb) begin
          state_d = ST_PAUSE;
        end else if (KO_qb) begin
          timer_d = '0;
        end else if (!freeze_power) begin
          if (timer_q == TERM) begin
            // Without a free slot the timer parks here and the spawn stays pending.
            if (found) begin
              en_d     = pick;
              active_d = active_d | pick;
              cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
              timer_d  = '0;
              for (int i = 0; i < N_BALL; i++) begin
                if (pick[i]) begin
                  move_d[6*i +: 6]  = lfsr_q[5:0];
                  xy_d[21*i +: 21]  = lfsr_q[6] ? xy_cube3 : xy_cube2;
                end
              end
            end
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (e_start_qb) begin
          state_d = ST_RUN;
          restart = 1'b1;
        end else if (e_resume_qb) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_STOP;
    endcase

    // Instances reinitialise on start themselves, so slots are released without br_end.
    if (restart) begin
      timer_d  = '0;
      active_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_STOP;
      timer_q  <= '0;
      lfsr_q   <= SEED;
      end_q    <= '1;
      active_q <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      move_q   <= '0;
      xy_q     <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lfsr_q   <= lfsr_d;
      end_q    <= br_end;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      move_q   <= move_d;
      xy_q     <= xy_d;
    end
  end

  assign e_enable_br = en_q;
  assign e_move_br   = move_q;
  assign e_XY0_br    = xy_q;
  assign br_active   = active_q;
  assign spawn_cnt   = cnt_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_boule_rouge_scheduler.sv
// Bench for boule_rouge_scheduler: directed game-flow scenarios plus random play,
// checked against a cycle-level behavioural model and a spawn scoreboard.
module tb_boule_rouge_scheduler;

  localparam int N  = 2;
  localparam int SD = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              e_start_qb, e_pause_qb, e_resume_qb, KO_qb, freeze_power;
  logic [20:0]       xy_cube2, xy_cube3;
  logic [N-1:0]      br_end;
  logic [N-1:0]      e_enable_br;
  logic [6*N-1:0]    e_move_br;
  logic [21*N-1:0]   e_XY0_br;
  logic [N-1:0]      br_active;
  logic [7:0]        spawn_cnt;
  logic [1:0]        sched_state;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] exp_q[$];

  // Reference model state
  int           m_state;
  int           m_timer;
  int           m_cnt;
  logic [N-1:0] m_active;
  logic [N-1:0] m_prev_end;
  logic [15:0]  m_lfsr;
  logic [5:0]   m_path[N];
  logic [20:0]  m_org[N];

  boule_rouge_scheduler #(
    .N_BALL(N), .SPAWN_DELAY(32'(SD)), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset),
    .e_start_qb(e_start_qb), .e_pause_qb(e_pause_qb), .e_resume_qb(e_resume_qb),
    .KO_qb(KO_qb), .freeze_power(freeze_power),
    .xy_cube2(xy_cube2), .xy_cube3(xy_cube3), .br_end(br_end),
    .e_enable_br(e_enable_br), .e_move_br(e_move_br), .e_XY0_br(e_XY0_br),
    .br_active(br_active), .spawn_cnt(spawn_cnt), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_timer    = 0;
    m_cnt      = 0;
    m_active   = '0;
    m_prev_end = '1;
    m_lfsr     = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      m_path[i] = '0;
      m_org[i]  = '0;
    end
    exp_q.delete();
  endtask

  // Behavioural model: one step of the game rules per clock edge.
  always @(posedge clk) begin
    logic [N-1:0] rises;
    logic [N-1:0] next_active;
    logic [N-1:0] mask;
    int           slot;
    if (!reset) begin
      rises       = br_end & ~m_prev_end;
      m_prev_end  = br_end;
      next_active = m_active & ~rises;
      if (m_state == 0) begin
        if (e_start_qb) begin
          m_state = 1; m_timer = 0; m_cnt = 0; next_active = '0;
        end
      end else if (m_state == 1) begin
        if (e_start_qb) begin
          m_timer = 0; m_cnt = 0; next_active = '0;
        end else if (e_pause_qb) begin
          m_state = 2;
        end else if (KO_qb) begin
          m_timer = 0;
        end else if (!freeze_power) begin
          if (m_timer == SD - 1) begin
            slot = -1;
            for (int i = 0; i < N; i++) begin
              if (!m_active[i]) begin
                slot = i;
                break;
              end
            end
            if (slot >= 0) begin
              m_path[slot]      = m_lfsr[5:0];
              m_org[slot]       = m_lfsr[6] ? xy_cube3 : xy_cube2;
              next_active[slot] = 1'b1;
              m_cnt             = (m_cnt < 255) ? m_cnt + 1 : 255;
              m_timer           = 0;
              mask              = '0;
              mask[slot]        = 1'b1;
              exp_q.push_back(mask);
            end
          end else begin
            m_timer = m_timer + 1;
          end
        end
      end else begin
        if (e_start_qb) begin
          m_state = 1; m_timer = 0; m_cnt = 0; next_active = '0;
        end else if (e_resume_qb) begin
          m_state = 1;
        end
      end
      m_active = next_active;
      m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each spawn pulse.
  always @(negedge clk) begin
    logic [6*N-1:0]  exp_move;
    logic [21*N-1:0] exp_xy;
    logic [N-1:0]    exp_en;
    for (int i = 0; i < N; i++) begin
      exp_move[6*i +: 6]  = m_path[i];
      exp_xy[21*i +: 21]  = m_org[i];
    end
    chk("sched_state", 64'(sched_state), 64'(m_state));
    chk("br_active", 64'(br_active), 64'(m_active));
    chk("spawn_cnt", 64'(spawn_cnt), 64'(m_cnt));
    chk("e_move_br", 64'(e_move_br), 64'(exp_move));
    chk("e_XY0_br", 64'(e_XY0_br), 64'(exp_xy));
    if (e_enable_br != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_spawn", 64'(e_enable_br), 64'(0));
      end else begin
        exp_en = exp_q.pop_front();
        chk("spawn_slot", 64'(e_enable_br), 64'(exp_en));
      end
    end
    if (exp_q.size() != 0) begin
      chk("missing_spawn", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  end

  task automatic tick();
    @(negedge clk);
    xy_cube2 = 21'($urandom);
    xy_cube3 = 21'($urandom);
  endtask

  task automatic pulse_start();  e_start_qb  = 1'b1; tick(); e_start_qb  = 1'b0; endtask
  task automatic pulse_pause();  e_pause_qb  = 1'b1; tick(); e_pause_qb  = 1'b0; endtask
  task automatic pulse_resume(); e_resume_qb = 1'b1; tick(); e_resume_qb = 1'b0; endtask

  task automatic wait_spawn(input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (e_enable_br == '0 && cycles < limit);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int extra;
    reset = 1'b1;
    e_start_qb = 0; e_pause_qb = 0; e_resume_qb = 0; KO_qb = 0; freeze_power = 0;
    br_end = '0; xy_cube2 = '0; xy_cube3 = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_state", 64'(sched_state), 64'(0));
    chk("reset_enable", 64'(e_enable_br), 64'(0));
    reset = 1'b0;
    repeat (5) tick();

    // First and second spawn, ten cycles apart, lowest slot first.
    pulse_start();
    chk("start_state", 64'(sched_state), 64'(1));
    wait_spawn(40, c);
    chk("first_spawn_delay", 64'(c), 64'(10));
    chk("first_spawn_slot", 64'(e_enable_br), 64'(2'b01));
    wait_spawn(40, c);
    chk("second_spawn_delay", 64'(c), 64'(10));
    chk("second_spawn_slot", 64'(e_enable_br), 64'(2'b10));
    extra = 0;
    repeat (100) begin
      tick();
      if (e_enable_br != '0) extra++;
    end
    chk("no_spawn_when_full", 64'(extra), 64'(0));

    // Release slot 0: cleared one cycle later, refilled the cycle after.
    br_end = 2'b01;
    tick();
    chk("release_active", 64'(br_active), 64'(2'b10));
    tick();
    chk("refill_slot", 64'(e_enable_br), 64'(2'b01));
    chk("refill_cnt", 64'(spawn_cnt), 64'(3));

    // Pause freezes everything; start during pause restarts.
    br_end = 2'b00;
    tick();
    br_end = 2'b10;
    repeat (3) tick();
    pulse_pause();
    chk("pause_state", 64'(sched_state), 64'(2));
    extra = 0;
    repeat (30) begin
      tick();
      if (e_enable_br != '0) extra++;
    end
    chk("no_spawn_in_pause", 64'(extra), 64'(0));
    pulse_resume();
    chk("resume_state", 64'(sched_state), 64'(1));
    repeat (4) tick();
    pulse_pause();
    e_start_qb = 1'b1; e_resume_qb = 1'b1;
    tick();
    e_start_qb = 1'b0; e_resume_qb = 1'b0;
    chk("restart_active", 64'(br_active), 64'(0));
    chk("restart_cnt", 64'(spawn_cnt), 64'(0));
    chk("restart_state", 64'(sched_state), 64'(1));

    // Random play against the model.
    for (int k = 0; k < 2500; k++) begin
      e_start_qb  = ($urandom_range(0, 299) == 0);
      e_pause_qb  = ($urandom_range(0, 99) == 0);
      e_resume_qb = ($urandom_range(0, 7) == 0);
      KO_qb       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) freeze_power = ~freeze_power;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) br_end[i] = ~br_end[i];
      end
      tick();
    end
    e_start_qb = 0; e_pause_qb = 0; e_resume_qb = 0; KO_qb = 0; freeze_power = 0;
    br_end = '0;

    // Asynchronous reset in the middle of a run with busy slots.
    pulse_start();
    repeat (25) tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_state", 64'(sched_state), 64'(0));
    chk("async_enable", 64'(e_enable_br), 64'(0));
    chk("async_move", 64'(e_move_br), 64'(0));
    chk("async_xy", 64'(e_XY0_br), 64'(0));
    chk("async_active", 64'(br_active), 64'(0));
    chk("async_cnt", 64'(spawn_cnt), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) br_end[i] = ~br_end[i];
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
